// File: rtl/bcd_pkg.sv
// Shared types and the single-digit BCD add rule for the sequential BCD adder.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {carry_out, digit}; a sum above 9 wraps by ten and carries.
  function automatic logic [BCD_W:0] bcd_digit_add(
    input logic [BCD_W-1:0] a,
    input logic [BCD_W-1:0] b,
    input logic             c
  );
    logic [BCD_W:0] s;
    s = (BCD_W+1)'(a) + (BCD_W+1)'(b) + (BCD_W+1)'(c);
    if (s > (BCD_W+1)'(9)) begin
      bcd_digit_add = {1'b1, BCD_W'(s - (BCD_W+1)'(10))};
    end else begin
      bcd_digit_add = {1'b0, s[BCD_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit BCD adder; chained by carry inside one group.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             c,
  output logic [BCD_W-1:0] sum_c,
  output logic             carry_c
);

  assign {carry_c, sum_c} = bcd_digit_add(a, b, c);

endmodule

// File: rtl/bcd_seq_adder.sv
// Multi-cycle BCD adder: DPC digits per clock with the carry registered between groups.
// Define BCD_SEQ_ADDER_CHECK_EN to flag non-BCD operand digits on err.
module bcd_seq_adder
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 100,
  parameter int unsigned DPC    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BCD_W*DIGITS-1:0]   a,
  input  logic [BCD_W*DIGITS-1:0]   b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   sum,
  output logic                      cout,
  output logic                      err
);

  localparam int unsigned W     = BCD_W * DIGITS;
  localparam int unsigned GRP_W = BCD_W * DPC;
  localparam int unsigned N     = DIGITS / DPC;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  if ((DIGITS % DPC) != 0) begin : g_cfg_err
    $error("bcd_seq_adder: DIGITS must be a multiple of DPC");
  end

  state_t             state;
  logic [CNT_W-1:0]   g;
  logic               carry;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [DPC:0]       chain_c;
  logic [GRP_W-1:0]   grp_sum_c;
  logic               accept_c;
  logic               last_c;

  assign accept_c = start && (state == IDLE || state == DONE);
  assign last_c   = (state == RUN) && (g == CNT_W'(N - 1));

  // Operands shift right each cycle, so the current group always sits in the low digits.
  assign chain_c[0] = carry;
  for (genvar i = 0; i < DPC; i++) begin : g_digit
    bcd_digit_adder u_digit (
      .a       (a_q[i*BCD_W +: BCD_W]),
      .b       (b_q[i*BCD_W +: BCD_W]),
      .c       (chain_c[i]),
      .sum_c   (grp_sum_c[i*BCD_W +: BCD_W]),
      .carry_c (chain_c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      g     <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept_c) begin
            a_q   <= a;
            b_q   <= b;
            carry <= cin;
            g     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> GRP_W;
          b_q   <= b_q >> GRP_W;
          // Result groups enter at the top; after N groups digit 0 lands at the bottom.
          sum   <= (sum >> GRP_W) | (W'(grp_sum_c) << (W - GRP_W));
          carry <= chain_c[DPC];
          g     <= g + CNT_W'(1);
          if (last_c) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cout  <= chain_c[DPC];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCD_SEQ_ADDER_CHECK_EN
  logic err_pending;

  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[i*BCD_W +: BCD_W] > BCD_W'(9)) bad = 1'b1;
    end
    return bad;
  endfunction

  // Flag captured with the operands, published alongside the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pending <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (accept_c) err_pending <= has_bad_digit(a) | has_bad_digit(b);
      if (last_c)   err         <= err_pending;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
